gb_regfile_ext: RTL and testbench

- Parametrised SM83 register file: A, F, B, C, D, E, H, L, SP and PC.
- Provides two 8-bit read ports, one 16-bit read port, 8-bit and 16-bit write ports, a 16-bit increment/decrement unit (IDU) for HL+/HL-/SP/PC, and a direct flag update path.
- Includes a snapshot dump sequencer that streams all 12 bytes over a valid/ready channel for save-state and debug.
- Sits between the CPU decoder/ALU and the debug/save-state controller.

---
 rtl/gb_cpu_pkg.sv | 35 +++
 rtl/gb_regfile_dump.sv | 59 +++++
 rtl/gb_regfile_ext.sv | 149 ++++++++++++++
 tb/tb_gb_regfile_ext.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_pkg.sv
// Shared SM83 register file constants: byte indices, pair codes, flag layout
// and the dump sequencer state type.
package gb_cpu_pkg;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_F = 3'd6;
  localparam logic [2:0] REG_A = 3'd7;

  localparam logic [2:0] PAIR_BC = 3'd0;
  localparam logic [2:0] PAIR_DE = 3'd1;
  localparam logic [2:0] PAIR_HL = 3'd2;
  localparam logic [2:0] PAIR_AF = 3'd3;
  localparam logic [2:0] PAIR_SP = 3'd4;
  localparam logic [2:0] PAIR_PC = 3'd5;

  localparam logic [7:0] F_MASK = 8'hF0;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  localparam int DUMP_BYTES = 12;

  typedef enum logic {
    DUMP_IDLE,
    DUMP_SEND
  } dump_state_e;

endpackage

// File: rtl/gb_regfile_dump.sv
// Snapshot dump sequencer: latches the 96-bit register image on request and
// streams it out one byte per valid/ready handshake, most significant byte first.
module gb_regfile_dump
  import gb_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [95:0] snap,
  input  logic        ready,
  output logic        busy,
  output logic        valid,
  output logic [3:0]  idx,
  output logic [7:0]  data
);

  dump_state_e state_q, state_nxt;
  logic [95:0] shift_q;
  logic [3:0]  idx_q;
  logic        xfer;
  logic        last;

  assign xfer = (state_q == DUMP_SEND) && ready;
  assign last = (idx_q == 4'(DUMP_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DUMP_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      DUMP_IDLE: if (start)        state_nxt = DUMP_SEND;
      DUMP_SEND: if (xfer && last) state_nxt = DUMP_IDLE;
      default:                     state_nxt = DUMP_IDLE;
    endcase
  end

  // Shifting in zeros leaves dump_data at 0 once the last byte has gone out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if ((state_q == DUMP_IDLE) && start) begin
      shift_q <= snap;
      idx_q   <= '0;
    end else if (xfer) begin
      shift_q <= {shift_q[87:0], 8'h00};
      idx_q   <= last ? 4'd0 : idx_q + 4'd1;
    end
  end

  assign busy  = (state_q == DUMP_SEND);
  assign valid = (state_q == DUMP_SEND);
  assign idx   = idx_q;
  assign data  = shift_q[95:88];

endmodule

// File: rtl/gb_regfile_ext.sv
// SM83 register file with byte/pair ports, 16-bit IDU, direct flag path and a
// save-state dump channel. Write collisions resolve per byte: w16 > w8 > idu > flags.
module gb_regfile_ext
  import gb_cpu_pkg::*;
#(
  parameter logic [15:0] RESET_AF = 16'h01B0,
  parameter logic [15:0] RESET_BC = 16'h0013,
  parameter logic [15:0] RESET_DE = 16'h00D8,
  parameter logic [15:0] RESET_HL = 16'h014D,
  parameter logic [15:0] RESET_SP = 16'hFFFE,
  parameter logic [15:0] RESET_PC = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  r8a_addr,
  output logic [7:0]  r8a_data,
  input  logic [2:0]  r8b_addr,
  output logic [7:0]  r8b_data,
  input  logic        w8_en,
  input  logic [2:0]  w8_addr,
  input  logic [7:0]  w8_data,
  input  logic [2:0]  r16_sel,
  output logic [15:0] r16_data,
  input  logic        w16_en,
  input  logic [2:0]  w16_sel,
  input  logic [15:0] w16_data,
  input  logic        idu_en,
  input  logic [2:0]  idu_sel,
  input  logic        idu_dec,
  input  logic        flags_we,
  input  logic [3:0]  flags_in,
  output logic [3:0]  flags_out,
  input  logic        dump_req,
  output logic        dump_busy,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [3:0]  dump_idx,
  output logic [7:0]  dump_data
);

  logic [7:0][7:0] r8_q, r8_nxt;
  logic [15:0]     sp_q, sp_nxt, pc_q, pc_nxt;
  logic [15:0]     idu_src, idu_val;
  logic [95:0]     snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r8_q[REG_A] <= RESET_AF[15:8];
      r8_q[REG_F] <= RESET_AF[7:0] & F_MASK;
      r8_q[REG_B] <= RESET_BC[15:8];
      r8_q[REG_C] <= RESET_BC[7:0];
      r8_q[REG_D] <= RESET_DE[15:8];
      r8_q[REG_E] <= RESET_DE[7:0];
      r8_q[REG_H] <= RESET_HL[15:8];
      r8_q[REG_L] <= RESET_HL[7:0];
      sp_q        <= RESET_SP;
      pc_q        <= RESET_PC;
    end else begin
      r8_q <= r8_nxt;
      sp_q <= sp_nxt;
      pc_q <= pc_nxt;
    end
  end

  always_comb begin
    r16_data = 16'h0000;
    case (r16_sel)
      PAIR_BC: r16_data = {r8_q[REG_B], r8_q[REG_C]};
      PAIR_DE: r16_data = {r8_q[REG_D], r8_q[REG_E]};
      PAIR_HL: r16_data = {r8_q[REG_H], r8_q[REG_L]};
      PAIR_AF: r16_data = {r8_q[REG_A], r8_q[REG_F]};
      PAIR_SP: r16_data = sp_q;
      PAIR_PC: r16_data = pc_q;
      default: r16_data = 16'h0000;
    endcase
  end

  // AF is not a legal IDU target, so its source is left at zero and never written.
  always_comb begin
    idu_src = 16'h0000;
    case (idu_sel)
      PAIR_BC: idu_src = {r8_q[REG_B], r8_q[REG_C]};
      PAIR_DE: idu_src = {r8_q[REG_D], r8_q[REG_E]};
      PAIR_HL: idu_src = {r8_q[REG_H], r8_q[REG_L]};
      PAIR_SP: idu_src = sp_q;
      PAIR_PC: idu_src = pc_q;
      default: idu_src = 16'h0000;
    endcase
    idu_val = idu_dec ? (idu_src - 16'd1) : (idu_src + 16'd1);
  end

  // Lowest priority first so each later write overrides the bytes it touches.
  always_comb begin
    r8_nxt = r8_q;
    sp_nxt = sp_q;
    pc_nxt = pc_q;
    if (flags_we) begin
      r8_nxt[REG_F][FLAG_Z] = flags_in[3];
      r8_nxt[REG_F][FLAG_N] = flags_in[2];
      r8_nxt[REG_F][FLAG_H] = flags_in[1];
      r8_nxt[REG_F][FLAG_C] = flags_in[0];
    end
    if (idu_en) begin
      case (idu_sel)
        PAIR_BC: {r8_nxt[REG_B], r8_nxt[REG_C]} = idu_val;
        PAIR_DE: {r8_nxt[REG_D], r8_nxt[REG_E]} = idu_val;
        PAIR_HL: {r8_nxt[REG_H], r8_nxt[REG_L]} = idu_val;
        PAIR_SP: sp_nxt = idu_val;
        PAIR_PC: pc_nxt = idu_val;
        default: ;
      endcase
    end
    if (w8_en) r8_nxt[w8_addr] = w8_data;
    if (w16_en) begin
      case (w16_sel)
        PAIR_BC: {r8_nxt[REG_B], r8_nxt[REG_C]} = w16_data;
        PAIR_DE: {r8_nxt[REG_D], r8_nxt[REG_E]} = w16_data;
        PAIR_HL: {r8_nxt[REG_H], r8_nxt[REG_L]} = w16_data;
        PAIR_AF: {r8_nxt[REG_A], r8_nxt[REG_F]} = w16_data;
        PAIR_SP: sp_nxt = w16_data;
        PAIR_PC: pc_nxt = w16_data;
        default: ;
      endcase
    end
    r8_nxt[REG_F] = r8_nxt[REG_F] & F_MASK;
  end

  assign r8a_data  = r8_q[r8a_addr];
  assign r8b_data  = r8_q[r8b_addr];
  assign flags_out = {r8_q[REG_F][FLAG_Z], r8_q[REG_F][FLAG_N],
                      r8_q[REG_F][FLAG_H], r8_q[REG_F][FLAG_C]};

  assign snap = {r8_q[REG_A], r8_q[REG_F], r8_q[REG_B], r8_q[REG_C],
                 r8_q[REG_D], r8_q[REG_E], r8_q[REG_H], r8_q[REG_L],
                 sp_q, pc_q};

  gb_regfile_dump u_dump (
    .clk   (clk),
    .rst_n (rst_n),
    .start (dump_req),
    .snap  (snap),
    .ready (dump_ready),
    .busy  (dump_busy),
    .valid (dump_valid),
    .idx   (dump_idx),
    .data  (dump_data)
  );

endmodule

// File: tb/tb_gb_regfile_ext.sv
// Self-checking bench for gb_regfile_ext: directed vector table, dump sequences
// and a randomized run against a byte-slot reference model.
module tb_gb_regfile_ext;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  r8a_addr, r8b_addr, w8_addr, r16_sel, w16_sel, idu_sel;
  logic [7:0]  r8a_data, r8b_data, w8_data, dump_data;
  logic        w8_en, w16_en, idu_en, idu_dec, flags_we;
  logic [15:0] r16_data, w16_data;
  logic [3:0]  flags_in, flags_out, dump_idx;
  logic        dump_req, dump_busy, dump_valid, dump_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gb_regfile_ext dut (
    .clk(clk), .rst_n(rst_n),
    .r8a_addr(r8a_addr), .r8a_data(r8a_data),
    .r8b_addr(r8b_addr), .r8b_data(r8b_data),
    .w8_en(w8_en), .w8_addr(w8_addr), .w8_data(w8_data),
    .r16_sel(r16_sel), .r16_data(r16_data),
    .w16_en(w16_en), .w16_sel(w16_sel), .w16_data(w16_data),
    .idu_en(idu_en), .idu_sel(idu_sel), .idu_dec(idu_dec),
    .flags_we(flags_we), .flags_in(flags_in), .flags_out(flags_out),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data)
  );

  typedef struct packed {
    logic        w8_en;
    logic [2:0]  w8_addr;
    logic [7:0]  w8_data;
    logic        w16_en;
    logic [2:0]  w16_sel;
    logic [15:0] w16_data;
    logic        idu_en;
    logic [2:0]  idu_sel;
    logic        idu_dec;
    logic        flags_we;
    logic [3:0]  flags_in;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [2:0]  rs16;
    logic [15:0] exp16;
    logic [2:0]  rs8;
    logic [7:0]  exp8;
    logic [3:0]  expfl;
  } vec_t;

  // Model: 12 byte slots in dump order A,F,B,C,D,E,H,L,SPh,SPl,PCh,PCl.
  logic [7:0] m[12];
  logic [7:0] nv[12];
  int         pr[12];

  function automatic int slot8(logic [2:0] a);
    case (a)
      3'd0: return 2;  3'd1: return 3;  3'd2: return 4;  3'd3: return 5;
      3'd4: return 6;  3'd5: return 7;  3'd6: return 1;  default: return 0;
    endcase
  endfunction

  function automatic int pair_hi(logic [2:0] p);
    case (p)
      3'd0: return 2;  3'd1: return 4;  3'd2: return 6;
      3'd3: return 0;  3'd4: return 8;  3'd5: return 10;
      default: return -1;
    endcase
  endfunction

  function automatic void model_reset();
    logic [7:0] init[12] = '{8'h01, 8'hB0, 8'h00, 8'h13, 8'h00, 8'hD8,
                             8'h01, 8'h4D, 8'hFF, 8'hFE, 8'h01, 8'h00};
    for (int k = 0; k < 12; k++) m[k] = init[k];
  endfunction

  function automatic void put(int slot, logic [7:0] val, int prio);
    if (prio > pr[slot]) begin
      nv[slot] = val;
      pr[slot] = prio;
    end
  endfunction

  function automatic void model_step(stim_t s);
    int h;
    logic [15:0] v;
    for (int k = 0; k < 12; k++) begin nv[k] = m[k]; pr[k] = -1; end
    h = pair_hi(s.w16_sel);
    if (s.w16_en && h >= 0) begin put(h, s.w16_data[15:8], 3); put(h + 1, s.w16_data[7:0], 3); end
    if (s.w8_en) put(slot8(s.w8_addr), s.w8_data, 2);
    h = pair_hi(s.idu_sel);
    if (s.idu_en && h > 0) begin
      v = {m[h], m[h + 1]};
      v = s.idu_dec ? v - 16'd1 : v + 16'd1;
      put(h, v[15:8], 1);
      put(h + 1, v[7:0], 1);
    end
    if (s.flags_we) put(1, {s.flags_in, 4'h0}, 0);
    for (int k = 0; k < 12; k++) m[k] = nv[k];
    m[1] = m[1] & 8'hF0;
  endfunction

  function automatic logic [15:0] model_r16(logic [2:0] p);
    int h = pair_hi(p);
    if (h < 0) return 16'h0000;
    return {m[h], m[h + 1]};
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic vec_t mk(logic w8e, logic [2:0] w8a, logic [7:0] w8d,
                              logic w16e, logic [2:0] w16s, logic [15:0] w16d,
                              logic ie, logic [2:0] is, logic id,
                              logic fwe, logic [3:0] fin,
                              logic [2:0] rs16, logic [15:0] e16,
                              logic [2:0] rs8, logic [7:0] e8, logic [3:0] efl);
    vec_t v;
    v.s = '{w8e, w8a, w8d, w16e, w16s, w16d, ie, is, id, fwe, fin};
    v.rs16 = rs16; v.exp16 = e16; v.rs8 = rs8; v.exp8 = e8; v.expfl = efl;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    w8_en = s.w8_en;   w8_addr = s.w8_addr;   w8_data = s.w8_data;
    w16_en = s.w16_en; w16_sel = s.w16_sel;   w16_data = s.w16_data;
    idu_en = s.idu_en; idu_sel = s.idu_sel;   idu_dec = s.idu_dec;
    flags_we = s.flags_we; flags_in = s.flags_in;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  vec_t       vecs[20];
  logic [7:0] exp_snap[12] = '{8'h11, 8'h20, 8'h33, 8'h44, 8'h55, 8'h66,
                               8'h77, 8'h88, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [7:0] exp3[12];

  initial begin
    stim_t s;
    int    got;
    bit    pstall, wrote, hit;
    logic [7:0] pdata;
    logic [3:0] pidx;

    vecs[0]  = mk(0,0,0,    0,0,0,       0,0,0, 0,4'h0, 3, 16'h01B0, 6, 8'hB0, 4'hB);
    vecs[1]  = mk(0,0,0,    0,0,0,       0,0,0, 0,4'h0, 0, 16'h0013, 0, 8'h00, 4'hB);
    vecs[2]  = mk(0,0,0,    0,0,0,       0,0,0, 0,4'h0, 4, 16'hFFFE, 1, 8'h13, 4'hB);
    vecs[3]  = mk(0,0,0,    0,0,0,       0,0,0, 0,4'h0, 5, 16'h0100, 5, 8'h4D, 4'hB);
    vecs[4]  = mk(0,0,0,    1,2,16'hFFFF,0,0,0, 0,4'h0, 2, 16'hFFFF, 4, 8'hFF, 4'hB);
    vecs[5]  = mk(0,0,0,    0,0,0,       1,2,0, 0,4'h0, 2, 16'h0000, 5, 8'h00, 4'hB);
    vecs[6]  = mk(0,0,0,    1,4,16'h0000,0,0,0, 0,4'h0, 4, 16'h0000, 7, 8'h01, 4'hB);
    vecs[7]  = mk(0,0,0,    0,0,0,       1,4,1, 0,4'h0, 4, 16'hFFFF, 3, 8'hD8, 4'hB);
    vecs[8]  = mk(1,1,8'hAA,1,0,16'h1234,1,0,0, 0,4'h0, 0, 16'h1234, 1, 8'h34, 4'hB);
    vecs[9]  = mk(0,0,0,    1,2,16'h00FF,0,0,0, 0,4'h0, 2, 16'h00FF, 4, 8'h00, 4'hB);
    vecs[10] = mk(1,4,8'h55,0,0,0,       1,2,0, 0,4'h0, 2, 16'h5500, 5, 8'h00, 4'hB);
    vecs[11] = mk(1,6,8'hFF,0,0,0,       0,0,0, 0,4'h0, 3, 16'h01F0, 6, 8'hF0, 4'hF);
    vecs[12] = mk(0,0,0,    0,0,0,       0,0,0, 1,4'h5, 3, 16'h0150, 6, 8'h50, 4'h5);
    vecs[13] = mk(0,0,0,    1,3,16'h12FF,0,0,0, 0,4'h0, 3, 16'h12F0, 7, 8'h12, 4'hF);
    vecs[14] = mk(0,0,0,    1,3,16'h3400,0,0,0, 1,4'hF, 3, 16'h3400, 6, 8'h00, 4'h0);
    vecs[15] = mk(0,0,0,    1,6,16'hBEEF,0,0,0, 0,4'h0, 6, 16'h0000, 2, 8'h00, 4'h0);
    vecs[16] = mk(0,0,0,    0,0,0,       1,3,0, 0,4'h0, 3, 16'h3400, 6, 8'h00, 4'h0);
    vecs[17] = mk(1,6,8'h80,0,0,0,       0,0,0, 1,4'hF, 3, 16'h3480, 6, 8'h80, 4'h8);
    vecs[18] = mk(0,0,0,    0,0,0,       1,5,0, 1,4'hA, 5, 16'h0101, 6, 8'hA0, 4'hA);
    vecs[19] = mk(0,0,0,    1,7,16'h1111,1,7,0, 0,4'h0, 7, 16'h0000, 0, 8'h12, 4'hA);

    rst_n = 1'b0;
    applyStimulus(idle());
    r8a_addr = 3'd0; r8b_addr = 3'd0; r16_sel = 3'd0;
    dump_req = 1'b0; dump_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_busy", 32'(dump_busy), 0);
    checkOutput("reset_valid", 32'(dump_valid), 0);
    checkOutput("reset_idx", 32'(dump_idx), 0);
    checkOutput("reset_data", 32'(dump_data), 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].s);
      @(posedge clk); #1;
      applyStimulus(idle());
      r16_sel = vecs[i].rs16;
      r8a_addr = vecs[i].rs8;
      #1;
      checkOutput($sformatf("vec%0d_r16", i), 32'(r16_data), 32'(vecs[i].exp16));
      checkOutput($sformatf("vec%0d_r8", i), 32'(r8a_data), 32'(vecs[i].exp8));
      checkOutput($sformatf("vec%0d_flags", i), 32'(flags_out), 32'(vecs[i].expfl));
    end

    // Preload the snapshot image used by the dump sequences.
    for (int i = 0; i < 6; i++) begin
      s = idle();
      s.w16_en = 1'b1;
      s.w16_sel = (i < 4) ? 3'(i) : 3'(i);
      s.w16_data = {exp_snap[pair_hi(3'(i))], exp_snap[pair_hi(3'(i)) + 1]};
      applyStimulus(s);
      @(posedge clk); #1;
    end
    applyStimulus(idle());

    dump_req = 1'b1; dump_ready = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("d1_valid%0d", i), 32'(dump_valid), 1);
      checkOutput($sformatf("d1_idx%0d", i), 32'(dump_idx), 32'(i));
      checkOutput($sformatf("d1_data%0d", i), 32'(dump_data), 32'(exp_snap[i]));
      @(posedge clk); #1;
    end
    checkOutput("d1_busy_end", 32'(dump_busy), 0);
    checkOutput("d1_valid_end", 32'(dump_valid), 0);

    dump_req = 1'b1; dump_ready = 1'b0;
    @(posedge clk); #1;
    dump_req = 1'b0;
    got = 0; pstall = 0; wrote = 0; pdata = '0; pidx = '0;
    for (int c = 0; c < 100 && got < 12; c++) begin
      if (pstall) begin
        checkOutput("d2_stall_data", 32'(dump_data), 32'(pdata));
        checkOutput("d2_stall_idx", 32'(dump_idx), 32'(pidx));
      end
      checkOutput("d2_valid", 32'(dump_valid), 1);
      checkOutput("d2_busy", 32'(dump_busy), 1);
      checkOutput("d2_idx", 32'(dump_idx), 32'(got));
      checkOutput("d2_data", 32'(dump_data), 32'(exp_snap[got]));
      s = idle();
      dump_ready = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (dump_idx == 4'd3 && !wrote) begin
        s.w8_en = 1'b1; s.w8_addr = 3'd7; s.w8_data = 8'hFF;
        wrote = 1;
      end
      applyStimulus(s);
      if (dump_valid && dump_ready) got++;
      pstall = dump_valid && !dump_ready;
      pdata = dump_data; pidx = dump_idx;
      @(posedge clk); #1;
    end
    applyStimulus(idle());
    checkOutput("d2_count", 32'(got), 12);
    checkOutput("d2_busy_end", 32'(dump_busy), 0);
    r8a_addr = 3'd7; #1;
    checkOutput("d2_a_written", 32'(r8a_data), 32'h0FF);

    // Same-cycle write to B at the request edge must not reach the snapshot.
    for (int k = 0; k < 12; k++) exp3[k] = exp_snap[k];
    exp3[0] = 8'hFF;
    s = idle(); s.w8_en = 1'b1; s.w8_addr = 3'd0; s.w8_data = 8'h00;
    applyStimulus(s);
    dump_req = 1'b1; dump_ready = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    applyStimulus(idle());
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (dump_valid && dump_idx == 4'd5) hit = 1;
      else begin
        if (dump_valid) checkOutput($sformatf("d3_data%0d", dump_idx), 32'(dump_data), 32'(exp3[dump_idx]));
        @(posedge clk); #1;
      end
    end
    checkOutput("d3_reached_idx5", 32'(hit), 1);
    rst_n = 1'b0; #1;
    checkOutput("d3_rst_valid", 32'(dump_valid), 0);
    checkOutput("d3_rst_busy", 32'(dump_busy), 0);
    #2 rst_n = 1'b1;
    dump_ready = 1'b0;
    model_reset();
    r16_sel = 3'd3; r8a_addr = 3'd7; #1;
    checkOutput("d3_rst_af", 32'(r16_data), 32'h01B0);
    checkOutput("d3_rst_a", 32'(r8a_data), 32'h01);
    r16_sel = 3'd5; #1;
    checkOutput("d3_rst_pc", 32'(r16_data), 32'h0100);
    @(posedge clk); #1;

    for (int c = 0; c < 300; c++) begin
      s.w8_en    = 1'($urandom_range(0, 1));
      s.w8_addr  = 3'($urandom_range(0, 7));
      s.w8_data  = 8'($urandom);
      s.w16_en   = 1'($urandom_range(0, 1));
      s.w16_sel  = 3'($urandom_range(0, 7));
      s.w16_data = 16'($urandom);
      s.idu_en   = 1'($urandom_range(0, 1));
      s.idu_sel  = 3'($urandom_range(0, 7));
      s.idu_dec  = 1'($urandom_range(0, 1));
      s.flags_we = 1'($urandom_range(0, 1));
      s.flags_in = 4'($urandom);
      applyStimulus(s);
      r16_sel  = 3'($urandom_range(0, 7));
      r8a_addr = 3'($urandom_range(0, 7));
      r8b_addr = 3'($urandom_range(0, 7));
      #1;
      checkOutput($sformatf("rnd%0d_r16", c), 32'(r16_data), 32'(model_r16(r16_sel)));
      checkOutput($sformatf("rnd%0d_r8a", c), 32'(r8a_data), 32'(m[slot8(r8a_addr)]));
      checkOutput($sformatf("rnd%0d_r8b", c), 32'(r8b_data), 32'(m[slot8(r8b_addr)]));
      checkOutput($sformatf("rnd%0d_flags", c), 32'(flags_out), 32'(m[1][7:4]));
      @(posedge clk);
      model_step(s);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
